// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the fifo_sync_flex family.
//   addr_width()  - memory address width for a given depth
//   read_mode_e   - read path selection (standard registered or first-word-fall-through)
//   DefaultDepth  - default number of entries
//   DefaultWidth  - default data word width
package fifo_pkg;

  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned DefaultWidth = 8;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } read_mode_e;

  // Address bits needed to index `depth` entries; never below 1 so that
  // degenerate depths still produce legal vector ranges.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DATA_WIDTH x FIFO_DEPTH storage array for the FIFO.
//   clk   - write clock, rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
// Contents are intentionally not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultWidth,
  parameter int unsigned FIFO_DEPTH = DefaultDepth,
  parameter int unsigned ADDR_WIDTH = addr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flex.sv
// fifo_sync_flex: single-clock FIFO with selectable read mode, occupancy count,
// programmable almost-full/almost-empty flags and sticky error flags.
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   wr_en, wdata - write request and data
//   rd_en        - read request (acknowledge in FWFT mode)
//   rdata        - read data (registered in standard mode, live head in FWFT mode)
//   full, empty  - occupancy == FIFO_DEPTH / == 0
//   almost_full  - count >= AFULL_THRESH
//   almost_empty - count <= AEMPTY_THRESH
//   count        - occupancy, 0..FIFO_DEPTH
//   overflow     - sticky: a write was rejected
//   underflow    - sticky: a read was rejected
//   clr_err      - synchronous clear of overflow/underflow (a new error wins)
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefaultWidth,
  parameter int unsigned FIFO_DEPTH    = DefaultDepth,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int unsigned AW = addr_width(FIFO_DEPTH);
  localparam read_mode_e Mode = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  typedef logic [AW:0] ptr_t;

  localparam ptr_t AfullTh  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AemptyTh = ptr_t'(AEMPTY_THRESH);

  // Elaboration-time parameter checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("fifo_sync_flex: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : gen_bad_afull
    $error("fifo_sync_flex: AFULL_THRESH must be in 1..FIFO_DEPTH");
  end
  if (AEMPTY_THRESH > FIFO_DEPTH - 1) begin : gen_bad_aempty
    $error("fifo_sync_flex: AEMPTY_THRESH must be in 0..FIFO_DEPTH-1");
  end

  // Pointers carry one extra wrap bit above the memory address.
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  ptr_t count_w;
  logic full_w, empty_w;
  logic wr_acc, rd_acc;

  logic [DATA_WIDTH-1:0] ram_rdata;

  // Occupancy decodes straight from the registered pointers; the modulo
  // subtraction stays exact across wrap because of the extra MSB.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write at full still goes through when a read frees the head slot in
  // the same cycle; a read at empty never does, even alongside a write.
  assign rd_acc = rd_en & ~empty_w;
  assign wr_acc = wr_en & (~full_w | rd_en);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    // Clear first so that a same-cycle error re-sets the flag.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (rd_en && !rd_acc) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  if (Mode == MODE_STD) begin : gen_std_read
    logic [DATA_WIDTH-1:0] rdata_q;

    // Captures the head before the edge, so a simultaneous write into the
    // same slot at full cannot leak wdata onto rdata.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata_q <= '0;
      end else if (rd_acc) begin
        rdata_q <= ram_rdata;
      end
    end

    assign rdata = rdata_q;
  end else begin : gen_fwft_read
    // Head of queue shown live; meaningless while empty.
    assign rdata = ram_rdata;
  end

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_w >= AfullTh);
  assign almost_empty = (count_w <= AemptyTh);
  assign count        = count_w;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
